// File: rtl/raster_sequencer_pkg.sv
// Shared timebase constants for the raster sequencer slice.
// Holds video standard cycle/line counts, counter widths and the strobe bundle.
package raster_sequencer_pkg;

    localparam int TICKS_PER_CYCLE = 32;
    localparam int DOTS_PER_CYCLE  = 8;
    localparam int TICKS_PER_DOT   = TICKS_PER_CYCLE / DOTS_PER_CYCLE;

    localparam int PAL_CYCLES      = 63;
    localparam int PAL_LINES       = 312;
    localparam int NTSC_CYCLES     = 65;
    localparam int NTSC_LINES      = 263;
    localparam int OLD_NTSC_CYCLES = 64;
    localparam int OLD_NTSC_LINES  = 262;

    localparam int T_W    = 5;
    localparam int XPOS_W = 10;
    localparam int CYC_W  = 7;
    localparam int LINE_W = 9;

    typedef struct packed {
        logic dot;
        logic phi_rise;
        logic line;
        logic frame;
    } strb_t;

endpackage

// File: rtl/raster_sequencer_if.sv
// Timebase bundle between the raster sequencer and its consumers.
// master: drives phase, counters, strobes, irq; receives raster_cmp/irq_ack.
interface raster_sequencer_if;
    import raster_sequencer_pkg::*;

    logic              clk_phi;
    logic [CYC_W-1:0]  cycle_num;
    logic [XPOS_W-1:0] xpos;
    logic [LINE_W-1:0] raster_line;
    logic              dot_stb;
    logic              phi_rise_stb;
    logic              line_start;
    logic              frame_start;
    logic              irq;
    logic [LINE_W-1:0] raster_cmp;
    logic              irq_ack;

    modport master (
        output clk_phi, cycle_num, xpos, raster_line,
        output dot_stb, phi_rise_stb, line_start, frame_start, irq,
        input  raster_cmp, irq_ack
    );

    modport slave (
        input  clk_phi, cycle_num, xpos, raster_line,
        input  dot_stb, phi_rise_stb, line_start, frame_start, irq,
        output raster_cmp, irq_ack
    );

endinterface

// File: rtl/raster_irq.sv
// Raster compare interrupt: registered comparator, rising-edge detect, pending latch.
// Ports: clk_dot4x, rst (sync, high), raster_line, raster_cmp, irq_ack in; irq out.
module raster_irq
    import raster_sequencer_pkg::*;
#(
    parameter int LINES_PER_FRAME = PAL_LINES
) (
    input  logic              clk_dot4x,
    input  logic              rst,
    input  logic [LINE_W-1:0] raster_line,
    input  logic [LINE_W-1:0] raster_cmp,
    input  logic              irq_ack,
    output logic              irq
);

    localparam logic [LINE_W-1:0] LINE_LIM = LINE_W'(LINES_PER_FRAME);

    logic [LINE_W-1:0] cmp_q, cmp_d;
    logic              match_prev_q, match_prev_d;
    logic              irq_q, irq_d;
    logic              match;
    logic              rise;

    always_comb begin
        cmp_d        = raster_cmp;
        match        = (raster_line == cmp_q) && (cmp_q < LINE_LIM);
        match_prev_d = match;
        rise         = match && !match_prev_q;
        // A new match edge beats a simultaneous acknowledge.
        if (rise) begin
            irq_d = 1'b1;
        end else if (irq_ack) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end
    end

    // match_prev resets high so a compare value of 0 cannot fire out of reset.
    always_ff @(posedge clk_dot4x) begin
        if (rst) begin
            cmp_q        <= '0;
            match_prev_q <= 1'b1;
            irq_q        <= 1'b0;
        end else begin
            cmp_q        <= cmp_d;
            match_prev_q <= match_prev_d;
            irq_q        <= irq_d;
        end
    end

    assign irq = irq_q;

endmodule

// File: rtl/raster_sequencer.sv
// Master video timebase: splits clk_dot4x into dots and phi half-cycles and
// drives clk_phi, cycle_num, xpos, raster_line, line/frame strobes and irq.
// Ports: clk_dot4x, rst (sync, high), bus (raster_sequencer_if.master).
// Build option RASTER_IRQ_EN adds the raster compare interrupt; else irq=0.
module raster_sequencer
    import raster_sequencer_pkg::*;
#(
    parameter int CYCLES_PER_LINE = PAL_CYCLES,
    parameter int LINES_PER_FRAME = PAL_LINES
) (
    input  logic               clk_dot4x,
    input  logic               rst,
    raster_sequencer_if.master bus
);

    localparam logic [T_W-1:0]    T_LAST    = T_W'(TICKS_PER_CYCLE - 1);
    localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(CYCLES_PER_LINE - 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(LINES_PER_FRAME - 1);

    logic              run_q, run_d;
    logic [T_W-1:0]    t_q, t_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [XPOS_W-1:0] xpos_q, xpos_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic              phi_q, phi_d;
    strb_t             strb_q, strb_d;
    logic              line_hit;

    // The first edge out of reset holds the counters at zero and only loads
    // the strobes, so the first released tick presents t=0 with its strobes.
    always_comb begin
        run_d  = 1'b1;
        t_d    = t_q;
        cyc_d  = cyc_q;
        xpos_d = xpos_q;
        line_d = line_q;
        if (run_q) begin
            t_d = (t_q == T_LAST) ? '0 : t_q + T_W'(1);
            if (t_q[1:0] == 2'd3) begin
                xpos_d = xpos_q + XPOS_W'(1);
            end
            if (t_q == T_LAST) begin
                if (cyc_q == CYC_LAST) begin
                    cyc_d  = '0;
                    xpos_d = '0;
                    line_d = (line_q == LINE_LAST) ? '0 : line_q + LINE_W'(1);
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
        end
        // Strobes decode the next state so they line up with the new counts.
        line_hit        = (t_d == '0) && (cyc_d == '0);
        phi_d           = t_d[T_W-1];
        strb_d.dot      = (t_d[1:0] == 2'd0);
        strb_d.phi_rise = (t_d == T_W'(TICKS_PER_CYCLE / 2));
        strb_d.line     = line_hit;
        strb_d.frame    = line_hit && (line_d == '0);
    end

    always_ff @(posedge clk_dot4x) begin
        if (rst) begin
            run_q  <= 1'b0;
            t_q    <= '0;
            cyc_q  <= '0;
            xpos_q <= '0;
            line_q <= '0;
            phi_q  <= 1'b0;
            strb_q <= '0;
        end else begin
            run_q  <= run_d;
            t_q    <= t_d;
            cyc_q  <= cyc_d;
            xpos_q <= xpos_d;
            line_q <= line_d;
            phi_q  <= phi_d;
            strb_q <= strb_d;
        end
    end

    assign bus.clk_phi      = phi_q;
    assign bus.cycle_num    = cyc_q;
    assign bus.xpos         = xpos_q;
    assign bus.raster_line  = line_q;
    assign bus.dot_stb      = strb_q.dot;
    assign bus.phi_rise_stb = strb_q.phi_rise;
    assign bus.line_start   = strb_q.line;
    assign bus.frame_start  = strb_q.frame;

`ifdef RASTER_IRQ_EN
    raster_irq #(
        .LINES_PER_FRAME(LINES_PER_FRAME)
    ) u_irq (
        .clk_dot4x  (clk_dot4x),
        .rst        (rst),
        .raster_line(line_q),
        .raster_cmp (bus.raster_cmp),
        .irq_ack    (bus.irq_ack),
        .irq        (bus.irq)
    );
`else
    logic unused_irq_in;
    assign unused_irq_in = ^{bus.raster_cmp, bus.irq_ack};
    assign bus.irq       = 1'b0;
`endif

endmodule

// File: tb/tb_raster_sequencer.sv
// Self-checking bench for raster_sequencer: PAL, NTSC and a scaled instance
// compared each tick against an arithmetic model of the timebase.
module tb_raster_sequencer;

    logic clk_dot4x = 1'b0;
    logic rst       = 1'b1;
    int   checks    = 0;
    int   errors    = 0;
    int   n         = 0;
    logic [2:0] exp_irq = '0;

    raster_sequencer_if pal_if();
    raster_sequencer_if ntsc_if();
    raster_sequencer_if sm_if();

    raster_sequencer dut_pal (
        .clk_dot4x(clk_dot4x),
        .rst      (rst),
        .bus      (pal_if)
    );

    raster_sequencer #(
        .CYCLES_PER_LINE(65),
        .LINES_PER_FRAME(263)
    ) dut_ntsc (
        .clk_dot4x(clk_dot4x),
        .rst      (rst),
        .bus      (ntsc_if)
    );

    // Scaled geometry so whole frames fit in a short run.
    raster_sequencer #(
        .CYCLES_PER_LINE(2),
        .LINES_PER_FRAME(5)
    ) dut_sm (
        .clk_dot4x(clk_dot4x),
        .rst      (rst),
        .bus      (sm_if)
    );

    always #5 clk_dot4x = ~clk_dot4x;

    logic [30:0] obs_pal, obs_ntsc, obs_sm;
    logic [95:0] obs_all;

    assign obs_pal = {pal_if.clk_phi, pal_if.cycle_num, pal_if.xpos,
                      pal_if.raster_line, pal_if.dot_stb, pal_if.phi_rise_stb,
                      pal_if.line_start, pal_if.frame_start};
    assign obs_ntsc = {ntsc_if.clk_phi, ntsc_if.cycle_num, ntsc_if.xpos,
                       ntsc_if.raster_line, ntsc_if.dot_stb, ntsc_if.phi_rise_stb,
                       ntsc_if.line_start, ntsc_if.frame_start};
    assign obs_sm = {sm_if.clk_phi, sm_if.cycle_num, sm_if.xpos,
                     sm_if.raster_line, sm_if.dot_stb, sm_if.phi_rise_stb,
                     sm_if.line_start, sm_if.frame_start};
    assign obs_all = {obs_pal, obs_ntsc, obs_sm,
                      pal_if.irq, ntsc_if.irq, sm_if.irq};

    // k = ticks since the first released tick.
    function automatic logic [30:0] model(input int cpl, input int lpf, input int k);
        int t;
        int lt;
        t  = k % 32;
        lt = 32 * cpl;
        return {(t >= 16), 7'(k / 32 % cpl), 10'(k / 4 % (cpl * 8)),
                9'(k / lt % lpf), (k % 4 == 0), (t == 16),
                (k % lt == 0), (k % (lt * lpf) == 0)};
    endfunction

    function automatic logic [95:0] expected();
        return {model(63, 312, n), model(65, 263, n), model(2, 5, n), exp_irq};
    endfunction

    task automatic adv();
        @(posedge clk_dot4x);
        #1;
        n++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pal_if.raster_cmp  = 9'h1FF;
        ntsc_if.raster_cmp = 9'h1FF;
        sm_if.raster_cmp   = 9'h1FF;
        pal_if.irq_ack     = 1'b0;
        ntsc_if.irq_ack    = 1'b0;
        sm_if.irq_ack      = 1'b0;
        repeat (3) adv();
        checks++;
        if (obs_all !== '0) begin
            errors++;
            $display("FAIL reset_state got %h want 0", obs_all);
        end
        rst = 1'b0;
        adv();
        n = 0;
        checks++;
        if ({pal_if.line_start, pal_if.frame_start, pal_if.dot_stb} !== 3'b111) begin
            errors++;
            $display("FAIL first_tick_strobes got %b want 111",
                     {pal_if.line_start, pal_if.frame_start, pal_if.dot_stb});
        end
        checks++;
        if (obs_all !== expected()) begin
            errors++;
            $display("FAIL timing n=%0d got %h want %h", n, obs_all, expected());
        end
    endtask

    task automatic test_phi_cycle();
        int lows;
        int highs;
        int rise_at;
        lows    = 0;
        highs   = 0;
        rise_at = -1;
        for (int i = 0; i < 32; i++) begin
            if (pal_if.clk_phi) highs++;
            else lows++;
            checks++;
            if (pal_if.clk_phi !== (i >= 16)) begin
                errors++;
                $display("FAIL phi_phase tick=%0d got %b want %b",
                         i, pal_if.clk_phi, (i >= 16));
            end
            if (pal_if.phi_rise_stb && rise_at < 0) rise_at = i;
            adv();
            checks++;
            if (obs_all !== expected()) begin
                errors++;
                $display("FAIL timing n=%0d got %h want %h", n, obs_all, expected());
            end
        end
        checks++;
        if (lows !== 16 || highs !== 16) begin
            errors++;
            $display("FAIL phi_duty got low=%0d high=%0d want 16/16", lows, highs);
        end
        checks++;
        if (rise_at !== 16) begin
            errors++;
            $display("FAIL phi_rise_tick got %0d want 16", rise_at);
        end
        checks++;
        if (pal_if.cycle_num !== 7'd1) begin
            errors++;
            $display("FAIL cycle_after_32 got %0d want 1", pal_if.cycle_num);
        end
    endtask

    task automatic test_pal_line();
        int max_x;
        int ls;
        max_x = 0;
        ls    = 0;
        while (n < 2020) begin
            adv();
            checks++;
            if (obs_all !== expected()) begin
                errors++;
                $display("FAIL timing n=%0d got %h want %h", n, obs_all, expected());
            end
            if (n < 2016 && int'(pal_if.xpos) > max_x) max_x = int'(pal_if.xpos);
            if (pal_if.line_start) ls++;
            if (n == 2016) begin
                checks++;
                if ({pal_if.xpos, pal_if.cycle_num, pal_if.raster_line} !==
                    {10'd0, 7'd0, 9'd1}) begin
                    errors++;
                    $display("FAIL pal_wrap got x=%0d c=%0d l=%0d want 0/0/1",
                             pal_if.xpos, pal_if.cycle_num, pal_if.raster_line);
                end
            end
        end
        checks++;
        if (max_x !== 503) begin
            errors++;
            $display("FAIL pal_xpos_max got %0d want 503", max_x);
        end
        checks++;
        if (ls !== 1) begin
            errors++;
            $display("FAIL pal_line_start_count got %0d want 1", ls);
        end
    endtask

    task automatic test_ntsc_line();
        int max_x;
        max_x = 0;
        while (n < 2085) begin
            adv();
            checks++;
            if (obs_all !== expected()) begin
                errors++;
                $display("FAIL timing n=%0d got %h want %h", n, obs_all, expected());
            end
            if (int'(ntsc_if.xpos) > max_x) max_x = int'(ntsc_if.xpos);
            if (n == 2080) begin
                checks++;
                if ({ntsc_if.xpos, ntsc_if.cycle_num, ntsc_if.raster_line} !==
                    {10'd0, 7'd0, 9'd1}) begin
                    errors++;
                    $display("FAIL ntsc_wrap got x=%0d c=%0d l=%0d want 0/0/1",
                             ntsc_if.xpos, ntsc_if.cycle_num, ntsc_if.raster_line);
                end
            end
        end
        checks++;
        if (max_x !== 519) begin
            errors++;
            $display("FAIL ntsc_xpos_max got %0d want 519", max_x);
        end
    endtask

    task automatic test_frame();
        int fs_sm;
        int fs_pal;
        int wraps;
        int max_l;
        int prev_l;
        fs_sm  = 0;
        fs_pal = 0;
        wraps  = 0;
        max_l  = 0;
        prev_l = int'(sm_if.raster_line);
        for (int i = 0; i < 640; i++) begin
            adv();
            checks++;
            if (obs_all !== expected()) begin
                errors++;
                $display("FAIL timing n=%0d got %h want %h", n, obs_all, expected());
            end
            if (sm_if.frame_start) fs_sm++;
            if (pal_if.frame_start) fs_pal++;
            if (prev_l == 4 && sm_if.raster_line == 9'd0) wraps++;
            if (int'(sm_if.raster_line) > max_l) max_l = int'(sm_if.raster_line);
            prev_l = int'(sm_if.raster_line);
        end
        checks++;
        if (fs_sm !== 2 || wraps !== 2 || max_l !== 4) begin
            errors++;
            $display("FAIL frame_wrap got fs=%0d wraps=%0d max=%0d want 2/2/4",
                     fs_sm, wraps, max_l);
        end
        checks++;
        if (fs_pal !== 0) begin
            errors++;
            $display("FAIL pal_frame_start_mid got %0d want 0", fs_pal);
        end
    endtask

`ifdef RASTER_IRQ_EN
    task automatic test_irq_line();
        int n0;
        int k3;
        while (n % 320 != 0) begin
            adv();
            checks++;
            if (obs_all !== expected()) begin
                errors++;
                $display("FAIL timing n=%0d got %h want %h", n, obs_all, expected());
            end
        end
        n0 = n;
        k3 = n0 + 192;
        sm_if.raster_cmp = 9'd3;
        while (n < n0 + 517) begin
            adv();
            exp_irq[0] = (n >= k3 + 1 && n <= k3 + 5) ||
                         (n >= n0 + 513 && n <= n0 + 515);
            checks++;
            if (obs_all !== expected()) begin
                errors++;
                $display("FAIL irq_line n=%0d got %h want %h", n, obs_all, expected());
            end
            sm_if.irq_ack = (n == k3 + 5) || (n == n0 + 515);
        end
        exp_irq = '0;
    endtask

    task automatic test_irq_range();
        sm_if.raster_cmp = 9'd5;
        for (int i = 0; i < 330; i++) begin
            adv();
            checks++;
            if (obs_all !== expected()) begin
                errors++;
                $display("FAIL irq_range n=%0d got %h want %h", n, obs_all, expected());
            end
        end
    endtask

    task automatic test_irq_cmp_write();
        int n1;
        int n2;
        logic [8:0] cur;
        while (n % 64 != 10) begin
            adv();
            checks++;
            if (obs_all !== expected()) begin
                errors++;
                $display("FAIL timing n=%0d got %h want %h", n, obs_all, expected());
            end
        end
        n1  = n;
        n2  = n1 + 12;
        cur = 9'(n / 64 % 5);
        sm_if.raster_cmp = cur;
        while (n < n2 + 10) begin
            adv();
            exp_irq[0] = (n >= n1 + 2 && n <= n1 + 4) ||
                         (n >= n2 + 2 && n <= n2 + 5);
            checks++;
            if (obs_all !== expected()) begin
                errors++;
                $display("FAIL irq_cmp_write n=%0d got %h want %h",
                         n, obs_all, expected());
            end
            sm_if.irq_ack = (n == n1 + 4) || (n == n2 + 1) || (n == n2 + 5);
            if (n == n1 + 8 || n == n2 + 8) sm_if.raster_cmp = 9'd7;
            if (n == n2) sm_if.raster_cmp = cur;
        end
        sm_if.irq_ack = 1'b0;
        exp_irq = '0;
    endtask
`else
    task automatic test_irq_disabled();
        pal_if.raster_cmp = 9'd0;
        for (int i = 0; i < 200; i++) begin
            sm_if.raster_cmp = 9'(n / 64 % 5);
            sm_if.irq_ack    = 1'($urandom_range(1, 0));
            adv();
            checks++;
            if (obs_all !== expected()) begin
                errors++;
                $display("FAIL irq_disabled n=%0d got %h want %h",
                         n, obs_all, expected());
            end
        end
        sm_if.irq_ack     = 1'b0;
        sm_if.raster_cmp  = 9'h1FF;
        pal_if.raster_cmp = 9'h1FF;
    endtask
`endif

    task automatic test_mid_reset();
        int span;
        span = int'($urandom_range(60, 20));
        for (int i = 0; i < span; i++) begin
            adv();
            checks++;
            if (obs_all !== expected()) begin
                errors++;
                $display("FAIL timing n=%0d got %h want %h", n, obs_all, expected());
            end
        end
        pal_if.raster_cmp = 9'd0;
        rst = 1'b1;
        adv();
        checks++;
        if (obs_all !== '0) begin
            errors++;
            $display("FAIL mid_reset got %h want 0", obs_all);
        end
        rst = 1'b0;
        adv();
        n = 0;
        for (int i = 0; i < 40; i++) begin
            checks++;
            if (obs_all !== expected()) begin
                errors++;
                $display("FAIL after_reset n=%0d got %h want %h",
                         n, obs_all, expected());
            end
            adv();
        end
    endtask

    initial begin
        test_reset();
        test_phi_cycle();
        test_pal_line();
        test_ntsc_line();
        test_frame();
`ifdef RASTER_IRQ_EN
        test_irq_line();
        test_irq_range();
        test_irq_cmp_write();
`else
        test_irq_disabled();
`endif
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog n=%0d", n);
        $fatal(1, "timeout");
    end

endmodule
